// File: rtl/fp16_sqrt_stream_if.sv
// Valid/ready/data stream carrying one fp16 value per transfer.
// master drives valid/data, slave drives ready.
interface fp16_sqrt_stream_if;
    logic        valid;
    logic        ready;
    logic [15:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fp16_sqrt_stream.sv
// Credit-based valid/ready wrapper around a fixed-latency fp16 sqrt core.
// Operands issue only when a result slot is reserved; results return in order.
module fp16_sqrt_stream #(
    parameter int LATENCY = 13,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    fp16_sqrt_stream_if.slave  in_bus,
    fp16_sqrt_stream_if.master out_bus,
    output logic [15:0]        core_a,
    input  logic [15:0]        core_result,
    output logic [CNT_W-1:0]   occupancy
);
    localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [LATENCY:1] vld_sr;
    logic [15:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             can_accept;
    logic             has_data;
    logic             fire;
    logic             pop;
    logic             capture;

    // in_ready depends on the credit count alone, never on out_ready.
    assign can_accept    = (occupancy < FULL);
    assign in_bus.ready  = can_accept;
    assign fire          = in_bus.valid & can_accept;
    assign core_a        = fire ? in_bus.data : 16'h0000;

    assign capture       = vld_sr[LATENCY];
    assign has_data      = (fifo_cnt != '0);
    assign out_bus.valid = has_data;
    assign out_bus.data  = has_data ? mem[rd_ptr] : 16'h0000;
    assign pop           = has_data & out_bus.ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else begin
            vld_sr[1] <= fire;
            for (int k = 2; k <= LATENCY; k++) begin
                vld_sr[k] <= vld_sr[k-1];
            end
        end
    end

    // NOTE: the storage array has no reset; pointers and fifo_cnt decide which entries are live.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= core_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            occupancy <= '0;
        end else begin
            if (capture) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            // The credit invariant guarantees a capture always finds a free slot.
            case ({capture, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({fire, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule

// File: tb/tb_fp16_sqrt_stream.sv
// Scoreboard bench for fp16_sqrt_stream: a delay-line core model feeds each DUT,
// stimulus pushes expected results, and per-DUT monitors pop and compare.
module tb_fp16_sqrt_stream;
    localparam int LAT   = 13;
    localparam int DEP   = 16;
    localparam int CW    = $clog2(DEP + 1);
    localparam int S_LAT = 3;
    localparam int S_DEP = 4;
    localparam int S_CW  = $clog2(S_DEP + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Core behaviour: sqrt lookup for the known operands, an opaque fixed mapping otherwise.
    function automatic logic [15:0] sqrt_ref(input logic [15:0] x);
        case (x)
            16'h4400: return 16'h4000;
            16'h3C00: return 16'h3C00;
            16'h4C00: return 16'h4400;
            16'hBC00: return 16'h7C01;
            default:  return x ^ 16'hA5C3;
        endcase
    endfunction

    // ---------------- main configuration ----------------
    fp16_sqrt_stream_if in_bus ();
    fp16_sqrt_stream_if out_bus ();
    logic [15:0]   core_a;
    logic [15:0]   core_result;
    logic [CW-1:0] occupancy;

    fp16_sqrt_stream #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .out_bus(out_bus),
        .core_a(core_a), .core_result(core_result), .occupancy(occupancy)
    );

    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= sqrt_ref(core_a);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign core_result = pipe[LAT-1];

    // ---------------- small configuration (wrap test) ----------------
    fp16_sqrt_stream_if s_in ();
    fp16_sqrt_stream_if s_out ();
    logic [15:0]     s_core_a;
    logic [15:0]     s_core_result;
    logic [S_CW-1:0] s_occupancy;

    fp16_sqrt_stream #(.LATENCY(S_LAT), .DEPTH(S_DEP)) u_small (
        .clk(clk), .rst_n(rst_n), .in_bus(s_in), .out_bus(s_out),
        .core_a(s_core_a), .core_result(s_core_result), .occupancy(s_occupancy)
    );

    logic [15:0] s_pipe [S_LAT];
    always @(posedge clk) begin
        s_pipe[0] <= sqrt_ref(s_core_a);
        for (int k = 1; k < S_LAT; k++) s_pipe[k] <= s_pipe[k-1];
    end
    assign s_core_result = s_pipe[S_LAT-1];

    // ---------------- scoreboards and monitors ----------------
    // Each entry holds the expected result and the first cycle it may be visible.
    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t q[$];
    exp_t sq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            check("occupancy", 32'(occupancy), q.size());
            check("in_ready", 32'(in_bus.ready), 32'(q.size() < DEP));
            check("out_valid", 32'(out_bus.valid), 32'(q.size() > 0 && q[0].due <= cyc));
            check("core_a", 32'(core_a), (in_bus.valid && in_bus.ready) ? 32'(in_bus.data) : 32'd0);
            if (out_bus.valid && out_bus.ready && q.size() > 0) begin
                check("out_data", 32'(out_bus.data), 32'(q[0].data));
                void'(q.pop_front());
            end
            if (in_bus.valid && in_bus.ready)
                q.push_back('{sqrt_ref(in_bus.data), cyc + LAT + 1});
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            sq.delete();
        end else begin
            check("s_occupancy", 32'(s_occupancy), sq.size());
            check("s_out_valid", 32'(s_out.valid), 32'(sq.size() > 0 && sq[0].due <= cyc));
            if (s_out.valid && s_out.ready && sq.size() > 0) begin
                check("s_out_data", 32'(s_out.data), 32'(sq[0].data));
                void'(sq.pop_front());
            end
            if (s_in.valid && s_in.ready)
                sq.push_back('{sqrt_ref(s_in.data), cyc + S_LAT + 1});
        end
    end

    // One clock cycle of stimulus: drive at posedge+1, observe handshakes at negedge.
    task automatic step(input logic v, input logic [15:0] d, input logic r,
                        output logic acc, output logic popd);
        in_bus.valid  = v;
        in_bus.data   = d;
        out_bus.ready = r;
        @(negedge clk);
        acc  = v && in_bus.ready;
        popd = out_bus.valid && r;
        @(posedge clk);
        #1;
    endtask

    task automatic sstep(input logic v, input logic [15:0] d, input logic r,
                         output logic acc, output logic popd);
        s_in.valid  = v;
        s_in.data   = d;
        s_out.ready = r;
        @(negedge clk);
        acc  = v && s_in.ready;
        popd = s_out.valid && r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [15:0] lut [4] = '{16'h3C00, 16'h4400, 16'h4C00, 16'hBC00};

    initial begin
        logic acc, pd, v, r;
        logic [15:0] d;
        int k, j, n, drops, nres, first, last, pops, seen, mism, occ_bad;

        in_bus.valid = 1'b0; in_bus.data = '0; out_bus.ready = 1'b0;
        s_in.valid   = 1'b0; s_in.data   = '0; s_out.ready   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_bus.ready), 1);
        check("rst_out_valid", 32'(out_bus.valid), 0);
        check("rst_out_data", 32'(out_bus.data), 0);
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_core_a", 32'(core_a), 0);
        rst_n = 1'b1;

        // Single operation: latency and occupancy 1 -> 0.
        step(1'b1, 16'h4400, 1'b1, acc, pd);
        check("single_accept", 32'(acc), 1);
        k = 1;
        while (!out_bus.valid && k < 60) begin
            step(1'b0, 16'h0000, 1'b1, acc, pd);
            k++;
        end
        check("single_latency", k, LAT + 1);
        check("single_data", 32'(out_bus.data), 32'h4000);
        check("single_occ_before_pop", 32'(occupancy), 1);
        step(1'b0, 16'h0000, 1'b1, acc, pd);
        check("single_occ_after_pop", 32'(occupancy), 0);

        // Back-to-back stream of 100 operands.
        j = 0; drops = 0; nres = 0; first = -1; last = -1;
        for (int i = 0; i < 100 + LAT + 20; i++) begin
            v = (j < 100);
            step(v, lut[j % 4], 1'b1, acc, pd);
            if (v && !acc) drops++;
            if (acc) j++;
            if (pd) begin
                nres++;
                if (first < 0) first = i;
                last = i;
            end
        end
        check("stream_ready_drops", drops, 0);
        check("stream_results", nres, 100);
        check("stream_contiguous", last - first + 1, 100);

        // Backpressure: 20 offered while the consumer stalls.
        j = 0;
        for (int i = 0; i < 40; i++) begin
            step(j < 20, 16'h1000 + 16'(j), 1'b0, acc, pd);
            if (acc) j++;
        end
        check("bp_accepted", j, DEP);
        check("bp_in_ready", 32'(in_bus.ready), 0);
        check("bp_occupancy", 32'(occupancy), DEP);
        pops = 0;
        step(1'b1, 16'h1000 + 16'(j), 1'b1, acc, pd);
        if (acc) j++;
        if (pd) pops++;
        check("bp_ready_after_pop", 32'(in_bus.ready), 1);
        for (int i = 0; i < 80; i++) begin
            step(j < 20, 16'h1000 + 16'(j), 1'b1, acc, pd);
            if (acc) j++;
            if (pd) pops++;
        end
        check("bp_delivered", pops, 20);
        check("bp_drained", 32'(occupancy), 0);

        // Random valid/ready at 50% each.
        for (int i = 0; i < 10000; i++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 3) == 0) ? lut[$urandom_range(0, 3)] : 16'($urandom);
            step(v, d, r, acc, pd);
        end
        n = 0;
        while (occupancy != '0 && n < 100) begin
            step(1'b0, 16'h0000, 1'b1, acc, pd);
            n++;
        end
        check("rand_drained_occ", 32'(occupancy), 0);
        check("rand_drained_sb", q.size(), 0);

        // Reset while operands are in flight.
        for (int i = 0; i < 3; i++) step(1'b1, lut[i], 1'b1, acc, pd);
        rst_n = 1'b0;
        step(1'b1, 16'h4C00, 1'b1, acc, pd);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 16'h0000, 1'b1, acc, pd);
            if (out_bus.valid) seen++;
        end
        check("rstmid_no_valid", seen, 0);
        check("rstmid_occupancy", 32'(occupancy), 0);
        check("rstmid_in_ready", 32'(in_bus.ready), 1);
        step(1'b1, 16'h3C00, 1'b1, acc, pd);
        k = 1;
        while (!out_bus.valid && k < 60) begin
            step(1'b0, 16'h0000, 1'b1, acc, pd);
            k++;
        end
        check("rstmid_latency", k, LAT + 1);
        check("rstmid_data", 32'(out_bus.data), 32'h3C00);
        step(1'b0, 16'h0000, 1'b1, acc, pd);

        // Small configuration: hold occupancy at 3 with paired fire/pop.
        for (int i = 0; i < 3; i++) sstep(1'b1, 16'h4400 + 16'(i), 1'b0, acc, pd);
        for (int i = 0; i < 6; i++) sstep(1'b0, 16'h0000, 1'b0, acc, pd);
        check("wrap_fill_occ", 32'(s_occupancy), 3);
        check("wrap_fill_valid", 32'(s_out.valid), 1);
        n = 0; mism = 0; occ_bad = 0;
        for (int i = 0; i < 50; i++) begin
            v = s_out.valid;
            sstep(v, 16'h2000 + 16'(n), 1'b1, acc, pd);
            if (acc != pd) mism++;
            if (acc) n++;
            if (s_occupancy != S_CW'(3)) occ_bad++;
        end
        check("wrap_pair_mismatch", mism, 0);
        check("wrap_occ_held", occ_bad, 0);
        check("wrap_enough_ops", 32'(n >= 8), 1);
        for (int i = 0; i < 10; i++) sstep(1'b0, 16'h0000, 1'b1, acc, pd);
        check("wrap_drained", 32'(s_occupancy), 0);
        check("wrap_sb_empty", sq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
